// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Each line holds a valid bit, a tag and four data bytes. A read miss
// fetches the whole 4-byte line from memory. A write always goes through
// to memory, and it updates the cached byte only when the write hits.
// Optional build macro: CACHE_STATS_EN adds saturating read hit/miss counters.
module cache_ctrl #(
    parameter int NUM_LINES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [9:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        cache_read_req_to_mem,
    output logic        cache_write_req_to_mem,
    output logic [9:0]  AddressBus,
    output logic [7:0]  dInputBus,
    input  logic [31:0] dOutputBus,
    input  logic        memoryRR,
`ifdef CACHE_STATS_EN
    output logic [15:0] hit_count,
    output logic [15:0] miss_count,
`endif
    input  logic        memoryWR
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 8 - IDX_W;

    typedef enum logic [2:0] {IDLE, CHECK, RD_MISS, WR_MEM, RESP} state_t;

    state_t state_reg, state_next;

    logic             req_we_reg;
    logic [9:0]       req_addr_reg;
    logic [7:0]       req_wdata_reg;

    logic [NUM_LINES-1:0] valid_reg;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [4:0]       byte_sh;
    logic             hit;
    logic             fill_done;

    assign req_idx = req_addr_reg[IDX_W+1:2];
    assign req_tag = req_addr_reg[9:IDX_W+2];
    // Byte at offset 0 sits in the top byte lane, so the shift is 8*(3-offset).
    assign byte_sh = {~req_addr_reg[1:0], 3'b000};
    assign hit     = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
    assign fill_done = (state_reg == RD_MISS) && memoryRR;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Capture the CPU request when it is accepted in IDLE
    always_ff @(posedge clk) begin
        if (state_reg == IDLE && cpu_req) begin
            req_we_reg    <= cpu_we;
            req_addr_reg  <= cpu_addr;
            req_wdata_reg <= cpu_wdata;
        end
    end

    // Valid bits: cleared by reset, set only when a fill completes
    always_ff @(posedge clk) begin
        if (rst)            valid_reg <= '0;
        else if (fill_done) valid_reg[req_idx] <= 1'b1;
    end

    // Tag/data storage: line fill on read miss, byte update on write hit
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_mem[req_idx] <= dOutputBus;
            tag_mem[req_idx]  <= req_tag;
        end else if (state_reg == CHECK && req_we_reg && hit) begin
            data_mem[req_idx][byte_sh +: 8] <= req_wdata_reg;
        end
    end

    // Read data register: loaded on read hit or fill completion, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata <= 8'h00;
        end else if (state_reg == CHECK && !req_we_reg && hit) begin
            cpu_rdata <= data_mem[req_idx][byte_sh +: 8];
        end else if (fill_done) begin
            cpu_rdata <= dOutputBus[byte_sh +: 8];
        end
    end

`ifdef CACHE_STATS_EN
    // Read hit/miss counters, counted once as the read leaves CHECK
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else if (state_reg == CHECK && !req_we_reg) begin
            if (hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else if (!memoryRR) begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

    // Next-state and output decode; memory buses are zero outside a request
    always_comb begin
        state_next             = state_reg;
        cpu_ready              = 1'b0;
        cache_read_req_to_mem  = 1'b0;
        cache_write_req_to_mem = 1'b0;
        AddressBus             = 10'h000;
        dInputBus              = 8'h00;
        case (state_reg)
            IDLE: begin
                if (cpu_req) state_next = CHECK;
            end
            CHECK: begin
                if (req_we_reg) begin
                    if (!memoryWR) state_next = WR_MEM;
                end else if (hit) begin
                    state_next = RESP;
                end else if (!memoryRR) begin
                    state_next = RD_MISS;
                end
            end
            RD_MISS: begin
                cache_read_req_to_mem = 1'b1;
                AddressBus            = {req_addr_reg[9:2], 2'b00};
                if (memoryRR) state_next = RESP;
            end
            WR_MEM: begin
                cache_write_req_to_mem = 1'b1;
                AddressBus             = req_addr_reg;
                dInputBus              = req_wdata_reg;
                if (memoryWR) state_next = RESP;
            end
            RESP: begin
                cpu_ready  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
